// File: rtl/minterm_eval_pkg.sv
// Shared types and helpers for the sequential sum-of-minterms evaluator.
package minterm_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [7:0] TT_DEFAULT_3 = 8'h3A;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/minterm_eval_lut.sv
// Combinational truth-table bit select: f = tt[vec], fn = ~f.
module minterm_lut
    import minterm_eval_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic [tt_width(N_IN)-1:0] tt,
    input  logic [N_IN-1:0]           vec,
    output logic                      f,
    output logic                      fn
);

    assign f  = tt[vec];
    assign fn = ~f;

endmodule

// File: rtl/minterm_eval_seq.sv
// Registered sum-of-minterms evaluator with single-eval and exhaustive-sweep modes.
// Optional sweep minterm counter enabled by defining MINTERM_EVAL_POPCNT_EN.
module minterm_eval_seq
    import minterm_eval_pkg::*;
#(
    parameter int                         N_IN    = 3,
    parameter logic [tt_width(N_IN)-1:0]  TT_INIT = TT_DEFAULT_3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tt_load,
    input  logic [tt_width(N_IN)-1:0] tt_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_IN-1:0]           in_vec,
    input  logic                      sweep_start,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_IN-1:0]           out_vec,
    output logic                      out_f,
    output logic                      out_fn,
    output logic                      busy,
    output logic                      sweep_done,
    output logic [N_IN:0]             ones_cnt
);

    localparam int TW = tt_width(N_IN);

    state_e          state_reg, state_next;
    logic [N_IN-1:0] idx_reg, idx_next;
    logic [TW-1:0]   tt_reg;
    logic            out_valid_reg;
    logic [N_IN-1:0] out_vec_reg;
    logic            out_f_reg;
    logic            out_fn_reg;

    logic            slot_free;
    logic            load;
    logic            tt_we;
    logic [N_IN-1:0] lut_vec;
    logic            lut_f;
    logic            lut_fn;

    assign slot_free = !out_valid_reg || out_ready;

    // One LUT serves both modes; the FSM steers which vector it sees.
    minterm_lut #(.N_IN(N_IN)) u_lut (
        .tt  (tt_reg),
        .vec (lut_vec),
        .f   (lut_f),
        .fn  (lut_fn)
    );

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        in_ready   = 1'b0;
        load       = 1'b0;
        tt_we      = 1'b0;
        sweep_done = 1'b0;
        lut_vec    = in_vec;
        case (state_reg)
            IDLE: begin
                in_ready = slot_free && !sweep_start;
                tt_we    = tt_load;
                if (sweep_start) begin
                    state_next = SWEEP;
                    idx_next   = '0;
                end else if (in_valid && slot_free) begin
                    load = 1'b1;
                end
            end
            SWEEP: begin
                lut_vec = idx_reg;
                if (slot_free) begin
                    load     = 1'b1;
                    idx_next = idx_reg + N_IN'(1);
                    if (idx_reg == '1) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_valid_reg && out_ready) begin
                    sweep_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            tt_reg        <= TT_INIT;
            out_valid_reg <= 1'b0;
            out_vec_reg   <= '0;
            out_f_reg     <= 1'b0;
            out_fn_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (tt_we) begin
                tt_reg <= tt_data;
            end
            if (load) begin
                out_valid_reg <= 1'b1;
                out_vec_reg   <= lut_vec;
                out_f_reg     <= lut_f;
                out_fn_reg    <= lut_fn;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_vec   = out_vec_reg;
    assign out_f     = out_f_reg;
    assign out_fn    = out_fn_reg;
    assign busy      = (state_reg != IDLE);

`ifdef MINTERM_EVAL_POPCNT_EN
    localparam int CW = N_IN + 1;

    logic          sweep_go;
    logic          sweep_load;
    logic          sweep_tag_reg;
    logic [CW-1:0] acc_reg;
    logic [CW-1:0] ones_reg;

    assign sweep_go   = (state_reg == IDLE) && sweep_start;
    assign sweep_load = (state_reg == SWEEP);

    // The tag keeps a single-eval result still pending at sweep start out of the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_tag_reg <= 1'b0;
            acc_reg       <= '0;
            ones_reg      <= '0;
        end else begin
            if (load) begin
                sweep_tag_reg <= sweep_load;
            end
            if (sweep_go) begin
                acc_reg <= '0;
            end else if (out_valid_reg && out_ready && sweep_tag_reg) begin
                acc_reg <= acc_reg + CW'(out_f_reg);
            end
            if (sweep_done) begin
                ones_reg <= acc_reg + CW'(out_f_reg);
            end
        end
    end

    assign ones_cnt = ones_reg;
`else
    assign ones_cnt = '0;
`endif

endmodule
